// File: rtl/axil_master_ctrl.sv
// axil_master_ctrl: turns single command-port requests into AXI-Lite write
// or read transactions and returns the result on a valid/ready response port.
// At most one transaction is outstanding at any time.
// Optional feature macro: AXIL_TIMEOUT_EN. When it is defined, a wait that
// lasts TIMEOUT_CYCLES cycles without BVALID/RVALID is aborted with resp 2'b11.
// When it is undefined, the block waits indefinitely for the response.
module axil_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,

    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,

    // write address channel
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,

    // write data channel
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,

    // write response channel
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,

    // read address channel
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,

    // read data channel
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    state_t state_reg;
    state_t state_next;

    // captured command
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic              write_reg;

    // captured response
    logic [31:0]       rdata_reg;
    logic [1:0]        resp_reg;

    // AW and W complete independently; each remembers its own handshake
    logic              aw_done_reg;
    logic              w_done_reg;

    // per-cycle events decoded by the FSM
    logic              cmd_fire;
    logic              aw_fire;
    logic              w_fire;
    logic              b_fire;
    logic              r_fire;
    logic              timeout_hit;
    logic              wait_expired;

`ifdef AXIL_TIMEOUT_EN
    // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer_reg;

    // Count cycles spent waiting for B/R; zero on every entry to a wait state.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            timer_reg <= '0;
        end else if (state_reg == WRESP || state_reg == RDATA) begin
            timer_reg <= timer_reg + 1'b1;
        end else begin
            timer_reg <= '0;
        end
    end

    // The wait is abandoned in the last of TIMEOUT_CYCLES waiting cycles.
    assign wait_expired = (timer_reg == TMR_LAST);
`else
    // Without the timeout feature the wait states never expire.
    assign wait_expired = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and channel handshake outputs. VALIDs come from state and
    // done flags only, never from the READY inputs.
    always_comb begin
        state_next    = state_reg;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        cmd_fire      = 1'b0;
        aw_fire       = 1'b0;
        w_fire        = 1'b0;
        b_fire        = 1'b0;
        r_fire        = 1'b0;
        timeout_hit   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Held low while reset is asserted so the reset value is 0.
                cmd_ready = M_AXI_ARESETN;
                cmd_fire  = cmd_valid && M_AXI_ARESETN;
                if (cmd_fire) begin
                    state_next = cmd_write ? WADDR : RADDR;
                end
            end

            WADDR: begin
                M_AXI_AWVALID = !aw_done_reg;
                M_AXI_WVALID  = !w_done_reg;
                aw_fire       = !aw_done_reg && M_AXI_AWREADY;
                w_fire        = !w_done_reg && M_AXI_WREADY;
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    state_next = WRESP;
                end
            end

            WRESP: begin
                M_AXI_BREADY = 1'b1;
                b_fire       = M_AXI_BVALID;
                if (b_fire) begin
                    state_next = RSP;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = RSP;
                end
            end

            RADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_next = RDATA;
                end
            end

            RDATA: begin
                M_AXI_RREADY = 1'b1;
                r_fire       = M_AXI_RVALID;
                if (r_fire) begin
                    state_next = RSP;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = RSP;
                end
            end

            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, per-channel done flags and response capture.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            write_reg   <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_reg    <= cmd_addr;
                wdata_reg   <= cmd_wdata;
                wstrb_reg   <= cmd_wstrb;
                write_reg   <= cmd_write;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (aw_fire) begin
                aw_done_reg <= 1'b1;
            end
            if (w_fire) begin
                w_done_reg <= 1'b1;
            end
            if (b_fire) begin
                resp_reg  <= M_AXI_BRESP;
                rdata_reg <= '0;
            end
            if (r_fire) begin
                resp_reg  <= M_AXI_RRESP;
                rdata_reg <= M_AXI_RDATA;
            end
            if (timeout_hit) begin
                resp_reg  <= RESP_TIMEOUT;
                rdata_reg <= '0;
            end
        end
    end

    // Payloads come straight from the capture registers, so they cannot move
    // while the matching VALID is high.
    assign M_AXI_AWADDR = addr_reg;
    assign M_AXI_ARADDR = addr_reg;
    assign M_AXI_WDATA  = wdata_reg;
    assign M_AXI_WSTRB  = wstrb_reg;

    assign rsp_write    = write_reg;
    assign rsp_rdata    = rdata_reg;
    assign rsp_resp     = resp_reg;

endmodule

// File: tb/tb_axil_master_ctrl.sv
// tb_axil_master_ctrl: directed test of axil_master_ctrl against a small
// behavioural model of the accelerator control-register slave
// (0x000: bit1 run, bit0 matw; 0x010: control; other addresses SLVERR).
// The timeout scenario is built only when AXIL_TIMEOUT_EN is defined.
module tb_axil_master_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic [3:0]        cmd_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;

    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    always #5 clk = ~clk;

    axil_master_ctrl #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          aw_cnt   = 0;
    int          w_cnt    = 0;
    bit          r_silent = 1'b0;
    bit          stray_b  = 1'b0;
    bit          stray_r  = 1'b0;

    logic [31:0] s_mem0 = '0;
    logic [31:0] s_mem1 = '0;
    logic        s_aw_got = 1'b0;
    logic        s_w_got  = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic [31:0] s_wdata  = '0;
    logic [3:0]  s_wstrb  = '0;
    logic        s_bvalid = 1'b0;
    logic [1:0]  s_bresp  = '0;
    logic        s_r_pend = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata  = '0;
    logic [1:0]  s_rresp  = '0;

    logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
    logic [31:0] eff_awaddr, eff_wdata;
    logic [3:0]  eff_wstrb;

    assign M_AXI_AWREADY = (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = (w_cnt >= w_delay);
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = s_bvalid | stray_b;
    assign M_AXI_BRESP   = s_bresp;
    assign M_AXI_RVALID  = s_rvalid | stray_r;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = s_rresp;

    assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
    assign have_aw    = aw_hs || s_aw_got;
    assign have_w     = w_hs || s_w_got;
    assign eff_awaddr = aw_hs ? M_AXI_AWADDR : s_awaddr;
    assign eff_wdata  = w_hs ? M_AXI_WDATA : s_wdata;
    assign eff_wstrb  = w_hs ? M_AXI_WSTRB : s_wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Slave: B the cycle after both AW and W are in; R two cycles after AR.
    always @(posedge clk) begin
        if (!aresetn) begin
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_bvalid <= 1'b0;
            s_r_pend <= 1'b0;
            s_rvalid <= 1'b0;
            aw_cnt   <= 0;
            w_cnt    <= 0;
        end else begin
            if (aw_hs) aw_cnt <= 0;
            else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (w_hs) w_cnt <= 0;
            else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;

            if (have_aw && have_w && !s_bvalid) begin
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
                s_bvalid <= 1'b1;
                if (eff_awaddr == 32'h0) begin
                    s_mem0  <= merge(s_mem0, eff_wdata, eff_wstrb);
                    s_bresp <= 2'b00;
                end else if (eff_awaddr == 32'h10) begin
                    s_mem1  <= merge(s_mem1, eff_wdata, eff_wstrb);
                    s_bresp <= 2'b00;
                end else begin
                    s_bresp <= 2'b10;
                end
            end else begin
                if (aw_hs) begin
                    s_aw_got <= 1'b1;
                    s_awaddr <= M_AXI_AWADDR;
                end
                if (w_hs) begin
                    s_w_got <= 1'b1;
                    s_wdata <= M_AXI_WDATA;
                    s_wstrb <= M_AXI_WSTRB;
                end
            end
            if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;

            if (ar_hs) begin
                s_r_pend <= 1'b1;
                s_araddr <= M_AXI_ARADDR;
            end else if (s_r_pend) begin
                s_r_pend <= 1'b0;
                if (!r_silent) begin
                    s_rvalid <= 1'b1;
                    if (s_araddr == 32'h0) begin
                        s_rdata <= s_mem0;
                        s_rresp <= 2'b00;
                    end else if (s_araddr == 32'h10) begin
                        s_rdata <= s_mem1;
                        s_rresp <= 2'b00;
                    end else begin
                        s_rdata <= 32'h0;
                        s_rresp <= 2'b10;
                    end
                end
            end
            if (s_rvalid && M_AXI_RREADY) s_rvalid <= 1'b0;
        end
    end

    // ---------------- channel monitor ----------------
    int          mon_aw = 0;
    int          mon_w  = 0;
    int          mon_b  = 0;
    int          mon_unstable = 0;
    logic        prev_awv = 1'b0;
    logic [31:0] prev_awaddr = '0;

    always @(negedge clk) begin
        if (M_AXI_AWVALID) mon_aw <= mon_aw + 1;
        if (M_AXI_WVALID) mon_w <= mon_w + 1;
        if (M_AXI_BVALID && M_AXI_BREADY) mon_b <= mon_b + 1;
        if (M_AXI_AWVALID && prev_awv && (M_AXI_AWADDR != prev_awaddr))
            mon_unstable <= mon_unstable + 1;
        prev_awv    <= M_AXI_AWVALID;
        prev_awaddr <= M_AXI_AWADDR;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
        checks++;
        if (obs !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expected);
        end
    endtask

    // Wait (bounded) for cmd_ready with cmd_valid high; returns just after
    // the accepting edge. n is the cycle number of the accepting cycle.
    task automatic wait_accept(output int n);
        bit got;
        got = 1'b0;
        n = -1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                n = cyc;
            end
        end
        check("cmd_accept", got, 1);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for rsp_valid, optionally stall rsp_ready, then consume.
    task automatic wait_rsp(input int stall, output logic [31:0] rd, output logic [1:0] rr,
                            output logic rw, output int rc);
        bit seen;
        int busy_ready;
        int unstable;
        seen = 1'b0;
        busy_ready = 0;
        unstable = 0;
        rc = -1;
        rd = '0;
        rr = '0;
        rw = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (cmd_ready) busy_ready++;
            if (rsp_valid) begin
                seen = 1'b1;
                rc = cyc;
                rd = rsp_rdata;
                rr = rsp_resp;
                rw = rsp_write;
            end
        end
        check("rsp_seen", seen, 1);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rr || rsp_write !== rw)
                unstable++;
            if (cmd_ready) busy_ready++;
        end
        if (stall > 0) check("rsp_stall_stable", unstable, 0);
        check("cmd_ready_busy", busy_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws, input int stall,
                           output logic [31:0] rd, output logic [1:0] rr, output logic rw,
                           output int lat);
        int n;
        int rc;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        wait_accept(n);
        cmd_valid = 1'b0;
        wait_rsp(stall, rd, rr, rw, rc);
        lat = rc - n;
        $display("txn %s %s addr=%h wdata=%h wstrb=%b -> rdata=%h resp=%b lat=%0d",
                 name, wr ? "WR" : "RD", a, wd, ws, rd, rr, lat);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rw;
        int          lat, n1, n2, r1, r2;
        int          a0, w0, b0, u0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID,
                           M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 7'b0);
        check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        check("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
        aresetn = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // stray B/R while idle must not be acknowledged
        stray_b = 1'b1;
        stray_r = 1'b1;
        @(negedge clk);
        check("stray_ready", {M_AXI_BREADY, M_AXI_RREADY, rsp_valid}, 3'b000);
        stray_b = 1'b0;
        stray_r = 1'b0;
        @(posedge clk);
        #1;

        // write run=1, matw=0
        run_cmd("w_run", 1'b1, 32'h000, 32'h0000_0002, 4'hF, 0, rd, rr, rw, lat);
        check("w_run_lat", lat, 3);
        check("w_run_rsp", {rw, rr, rd}, {1'b1, 2'b00, 32'h0});
        check("slave_run_matw", {s_mem0[1], s_mem0[0]}, 2'b10);

        // read it back
        run_cmd("r_run", 1'b0, 32'h000, 32'h0, 4'h0, 0, rd, rr, rw, lat);
        check("r_run_lat", lat, 4);
        check("r_run_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'h0000_0002});

        // back-to-back: write 0x010 then read 0x010 with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h010;
        cmd_wdata = 32'hDEAD_BEEF;
        cmd_wstrb = 4'hF;
        wait_accept(n1);
        cmd_write = 1'b0;
        cmd_wdata = 32'h0;
        wait_rsp(0, rd, rr, rw, r1);
        $display("txn b2b_w WR addr=%h wdata=%h -> resp=%b lat=%0d", 32'h010, 32'hDEAD_BEEF, rr, r1 - n1);
        check("b2b_w_lat", r1 - n1, 3);
        check("b2b_w_rsp", {rw, rr}, 3'b100);
        wait_accept(n2);
        cmd_valid = 1'b0;
        check("b2b_accept_gap", n2 - r1, 1);
        wait_rsp(0, rd, rr, rw, r2);
        $display("txn b2b_r RD addr=%h -> rdata=%h resp=%b lat=%0d", 32'h010, rd, rr, r2 - n2);
        check("b2b_r_lat", r2 - n2, 4);
        check("b2b_r_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'hDEAD_BEEF});

        // partial strobes: bytes 0 and 2 of 0xDEADBEEF replaced -> 0xDE22BE44
        run_cmd("w_strb", 1'b1, 32'h010, 32'h1122_3344, 4'b0101, 0, rd, rr, rw, lat);
        check("w_strb_rsp", {rw, rr, rd}, {1'b1, 2'b00, 32'h0});
        run_cmd("r_strb", 1'b0, 32'h010, 32'h0, 4'h0, 0, rd, rr, rw, lat);
        check("r_strb_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'hDE22_BE44});

        // unmapped address returns SLVERR
        run_cmd("r_bad", 1'b0, 32'h020, 32'h0, 4'h0, 0, rd, rr, rw, lat);
        check("r_bad_rsp", {rw, rr, rd}, {1'b0, 2'b10, 32'h0});

        // AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3;
        a0 = mon_aw;
        w0 = mon_w;
        b0 = mon_b;
        u0 = mon_unstable;
        run_cmd("w_awdly", 1'b1, 32'h000, 32'h0000_0001, 4'hF, 0, rd, rr, rw, lat);
        aw_delay = 0;
        check("awdly_aw_cycles", mon_aw - a0, 4);
        check("awdly_w_cycles", mon_w - w0, 1);
        check("awdly_b_count", mon_b - b0, 1);
        check("awdly_addr_stable", mon_unstable - u0, 0);
        check("awdly_lat", lat, 6);
        check("awdly_rsp", {rw, rr}, 3'b100);
        check("awdly_mem", s_mem0, 32'h0000_0001);

        // response held off for 5 cycles
        run_cmd("r_stall", 1'b0, 32'h000, 32'h0, 4'h0, 5, rd, rr, rw, lat);
        check("r_stall_lat", lat, 4);
        check("r_stall_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'h0000_0001});

`ifdef AXIL_TIMEOUT_EN
        // slave never answers: RDATA entered at accept+2, abort 16 cycles later
        r_silent = 1'b1;
        run_cmd("r_tmo", 1'b0, 32'h000, 32'h0, 4'h0, 0, rd, rr, rw, lat);
        r_silent = 1'b0;
        check("tmo_lat", lat, 18);
        check("tmo_rsp", {rw, rr, rd}, {1'b0, 2'b11, 32'h0});
`endif

        // reset while AW/W are pending
        aw_delay  = 5;
        w_delay   = 5;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h010;
        cmd_wdata = 32'hCAFE_F00D;
        cmd_wstrb = 4'hF;
        wait_accept(n1);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("waddr_valid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        aresetn = 1'b0;
        @(negedge clk);
        check("rst_mid_drop", {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, rsp_valid}, 4'b0000);
        @(negedge clk);
        aresetn  = 1'b1;
        aw_delay = 0;
        w_delay  = 0;
        @(negedge clk);
        check("rst_mid_recover", {cmd_ready, rsp_valid}, 2'b10);
        $display("txn rst_abort WR addr=%h wdata=%h -> discarded by reset", 32'h010, 32'hCAFE_F00D);
        @(posedge clk);
        #1;

        // aborted write must not have reached the slave
        run_cmd("r_after_rst", 1'b0, 32'h010, 32'h0, 4'h0, 0, rd, rr, rw, lat);
        check("after_rst_lat", lat, 4);
        check("after_rst_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'hDE22_BE44});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
